// File: rtl/cvt_issue_ctrl.sv
// Two-stage issue/writeback sequencer for the FPU conversion datapath (decode_cvt + cvt inside).
// Optional saturating statistics counters are compiled in with `define CVT_STATS_EN.
package cvt_issue_pkg;
  typedef enum logic [1:0] {
    CVT_NONE = 2'd0,
    CVT_S_W  = 2'd1,
    CVT_W_S  = 2'd2,
    CVT_PS_S = 2'd3
  } cvt_sel_e;

  localparam logic [4:0] FMT_S     = 5'h10;
  localparam logic [4:0] FMT_W     = 5'h14;
  localparam logic [5:0] OP_CVT_S  = 6'h20;
  localparam logic [5:0] OP_CVT_W  = 6'h24;
  localparam logic [5:0] OP_CVT_PS = 6'h26;
endpackage

module decode_cvt
  import cvt_issue_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] fmt,
  input  logic       fd,
  output cvt_sel_e   sel,
  output logic [1:0] we
);
  always_comb begin
    sel = CVT_NONE;
    we  = 2'b00;
    if (fmt == FMT_W && opcode == OP_CVT_S) begin
      sel = CVT_S_W;
      we  = fd ? 2'b10 : 2'b01;
    end else if (fmt == FMT_S && opcode == OP_CVT_W) begin
      sel = CVT_W_S;
      we  = fd ? 2'b10 : 2'b01;
    end else if (fmt == FMT_S && opcode == OP_CVT_PS) begin
      sel = CVT_PS_S;
      we  = 2'b11;
    end
  end
endmodule

module cvt
  import cvt_issue_pkg::*;
(
  input  cvt_sel_e    sel,
  input  logic [63:0] dina,
  input  logic [63:0] dinb,
  output logic [63:0] dout
);
  // Signed int32 -> binary32, round to nearest even.
  function automatic logic [31:0] int_to_single(input logic [31:0] x);
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  msb;
    logic [7:0]  exp_b;
    logic        rnd;
    logic [30:0] body;
    mag = x[31] ? (~x + 32'd1) : x;
    msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm  = mag << (5'd31 - msb);
    exp_b = 8'd127 + {3'b000, msb};
    rnd   = norm[7] & ((|norm[6:0]) | norm[8]);
    // A mantissa carry-out ripples into the exponent field on purpose.
    body  = {exp_b, norm[30:8]} + {30'b0, rnd};
    return (x == 32'd0) ? 32'd0 : {x[31], body};
  endfunction

  // binary32 -> signed int32, round to nearest even; NaN/overflow give 0x7FFFFFFF.
  function automatic logic [31:0] single_to_int(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] m;
    logic [63:0] ext;
    logic [23:0] ip;
    logic        rnd;
    logic [30:0] mag;
    logic [31:0] res;
    e   = f[30:23];
    m   = {1'b1, f[22:0]};
    ext = '0;
    ip  = '0;
    rnd = 1'b0;
    mag = '0;
    if (e >= 8'd158) begin
      res = (f[31] && e == 8'd158 && f[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e < 8'd126) begin
      res = 32'd0;
    end else begin
      if (e >= 8'd150) begin
        mag = 31'(m) << (e - 8'd150);
      end else begin
        ext = {m, 40'b0} >> (8'd150 - e);
        ip  = ext[63:40];
        rnd = ext[39] & ((|ext[38:0]) | ext[40]);
        mag = {7'b0, ip} + {30'b0, rnd};
      end
      res = f[31] ? (~{1'b0, mag} + 32'd1) : {1'b0, mag};
    end
    return res;
  endfunction

  logic unused_hi;
  assign unused_hi = ^{dina[63:32], dinb[63:32]};

  always_comb begin
    dout = '0;
    case (sel)
      CVT_S_W:  dout = {32'b0, int_to_single(dina[31:0])};
      CVT_W_S:  dout = {32'b0, single_to_int(dina[31:0])};
      CVT_PS_S: dout = {dina[31:0], dinb[31:0]};
      default:  dout = '0;
    endcase
  end
endmodule

module cvt_issue_ctrl
  import cvt_issue_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_fmt,
  input  logic        in_fd,
  input  logic [4:0]  in_dest,
  input  logic [63:0] in_fs,
  input  logic [63:0] in_ft,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_we,
  output logic [4:0]  out_dest,
  output logic [63:0] out_data,
  output logic        illegal,
  output logic        busy,
  input  logic [4:0]  hz_reg,
  output logic        hz_hit
`ifdef CVT_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_done,
  output logic [CNT_W-1:0] cnt_illegal
`endif
);
  // Handshake: a transfer happens on a cycle where valid & ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.
  cvt_sel_e    dec_sel;
  logic [1:0]  dec_we;
  logic        legal;
  logic        accept;
  logic        s2_adv;
  logic        retire;

  logic        s1_valid;
  cvt_sel_e    s1_sel;
  logic [1:0]  s1_we;
  logic [4:0]  s1_dest;
  logic [63:0] s1_fs;
  logic [63:0] s1_ft;
  logic [63:0] cvt_dout;

  logic        s2_valid;
  logic [1:0]  s2_we;
  logic [4:0]  s2_dest;
  logic [63:0] s2_data;
  logic        illegal_q;

  decode_cvt u_decode (
    .opcode (in_opcode),
    .fmt    (in_fmt),
    .fd     (in_fd),
    .sel    (dec_sel),
    .we     (dec_we)
  );

  cvt u_cvt (
    .sel  (s1_sel),
    .dina (s1_fs),
    .dinb (s1_ft),
    .dout (cvt_dout)
  );

  assign s2_adv   = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~flush & (~s1_valid | s2_adv);
  assign accept   = in_valid & in_ready;
  assign legal    = |dec_we;
  assign retire   = s2_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= CVT_NONE;
      s1_we    <= 2'b00;
      s1_dest  <= 5'd0;
      s1_fs    <= 64'd0;
      s1_ft    <= 64'd0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept && legal) begin
      s1_valid <= 1'b1;
      s1_sel   <= dec_sel;
      s1_we    <= dec_we;
      s1_dest  <= in_dest;
      s1_fs    <= in_fs;
      s1_ft    <= in_ft;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Retire and refill in the same cycle keeps S2 full with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_we    <= 2'b00;
      s2_dest  <= 5'd0;
      s2_data  <= 64'd0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      s2_we    <= s1_we;
      s2_dest  <= s1_dest;
      s2_data  <= cvt_dout;
    end else if (retire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= accept & ~legal & ~flush;
  end

  assign out_valid = s2_valid;
  assign out_we    = s2_valid ? s2_we : 2'b00;
  assign out_dest  = s2_valid ? s2_dest : 5'd0;
  assign out_data  = s2_data;
  assign illegal   = illegal_q;
  assign busy      = s1_valid | s2_valid;
  assign hz_hit    = (s1_valid & (s1_dest == hz_reg)) | (s2_valid & (s2_dest == hz_reg));

`ifdef CVT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_done    <= '0;
      cnt_illegal <= '0;
    end else begin
      if (retire && !(&cnt_done))       cnt_done    <= cnt_done + CNT_W'(1);
      if (illegal_q && !(&cnt_illegal)) cnt_illegal <= cnt_illegal + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_cvt_issue_ctrl.sv
// Bench for cvt_issue_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// Counter checks are compiled in when CVT_STATS_EN is defined.
module tb_cvt_issue_ctrl;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = '0;
  logic [4:0]  in_fmt = '0;
  logic        in_fd = 1'b0;
  logic [4:0]  in_dest = '0;
  logic [63:0] in_fs = '0;
  logic [63:0] in_ft = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_we;
  logic [4:0]  out_dest;
  logic [63:0] out_data;
  logic        illegal;
  logic        busy;
  logic [4:0]  hz_reg = '0;
  logic        hz_hit;
`ifdef CVT_STATS_EN
  logic [CNT_W-1:0] cnt_done;
  logic [CNT_W-1:0] cnt_illegal;
`endif

  always #5 clk = ~clk;

  cvt_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_fmt    (in_fmt),
    .in_fd     (in_fd),
    .in_dest   (in_dest),
    .in_fs     (in_fs),
    .in_ft     (in_ft),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_we    (out_we),
    .out_dest  (out_dest),
    .out_data  (out_data),
    .illegal   (illegal),
    .busy      (busy),
    .hz_reg    (hz_reg),
    .hz_hit    (hz_hit)
`ifdef CVT_STATS_EN
    ,
    .cnt_done    (cnt_done),
    .cnt_illegal (cnt_illegal)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_i2f(input logic [31:0] x);
    longint mag, q, rem, half, p2;
    int e;
    logic s;
    if (x == 32'd0) return 32'd0;
    s = x[31];
    mag = longint'($signed(x));
    if (mag < 0) mag = -mag;
    e = 0;
    while ((longint'(1) << (e + 1)) <= mag) e++;
    if (e <= 23) begin
      q = mag << (23 - e);
    end else begin
      p2 = longint'(1) << (e - 23);
      q = mag / p2;
      rem = mag % p2;
      half = p2 / 2;
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (longint'(1) << 24)) begin
        q = q / 2;
        e++;
      end
    end
    return {s, 8'(e + 127), 23'(q - (longint'(1) << 23))};
  endfunction

  function automatic logic [31:0] ref_f2i(input logic [31:0] f);
    int e, sh;
    longint m, q, rem, half, p2, v;
    e = int'(f[30:23]);
    if (e == 255 || e >= 180) return 32'h7FFF_FFFF;
    m = (longint'(1) << 23) + longint'(f[22:0]);
    if (e >= 150) begin
      q = m << (e - 150);
    end else begin
      sh = 150 - e;
      if (sh > 40) begin
        q = 0;
      end else begin
        p2 = longint'(1) << sh;
        q = m / p2;
        rem = m % p2;
        half = p2 / 2;
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
      end
    end
    v = f[31] ? -q : q;
    if (v >= longint'(32'h8000_0000) || v < -longint'(32'h8000_0000)) return 32'h7FFF_FFFF;
    return 32'(v);
  endfunction

  // Returns {legal, we, dest, data}.
  function automatic logic [71:0] ref_op(input logic [4:0] fmt, input logic [5:0] op,
                                         input logic fd, input logic [4:0] dest,
                                         input logic [63:0] fs, input logic [63:0] ft);
    logic [1:0] half_we;
    half_we = fd ? 2'b10 : 2'b01;
    if (fmt == 5'h14 && op == 6'h20) return {1'b1, half_we, dest, 32'h0, ref_i2f(fs[31:0])};
    if (fmt == 5'h10 && op == 6'h24) return {1'b1, half_we, dest, 32'h0, ref_f2i(fs[31:0])};
    if (fmt == 5'h10 && op == 6'h26) return {1'b1, 2'b11, dest, fs[31:0], ft[31:0]};
    return {1'b0, 71'd0};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [70:0] exp_q[$];
  logic        exp_ill = 1'b0;
  int          n_done = 0;
  int          n_ill = 0;
  logic [71:0] mon_r;
  logic        mon_acc;
  logic [70:0] mon_e;

  function automatic logic hz_model(input logic [4:0] r);
    foreach (exp_q[i]) if (exp_q[i][68:64] == r) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_ill = 1'b0;
      n_done = 0;
      n_ill = 0;
    end else begin
      check("busy", busy, exp_q.size() != 0);
      check("in_ready", in_ready, !flush && (exp_q.size() < 2 || out_ready));
      check("illegal", illegal, exp_ill);
      if (exp_ill) n_ill++;
      check("hz_hit", hz_hit, hz_model(hz_reg));
      if (!out_valid) check("we_dest_qual", {out_we, out_dest}, 7'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", out_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("writeback", {out_we, out_dest, out_data}, mon_e);
          n_done++;
        end
      end
      mon_acc = in_valid & in_ready;
      mon_r = ref_op(in_fmt, in_opcode, in_fd, in_dest, in_fs, in_ft);
      if (flush) exp_q.delete();
      if (mon_acc && mon_r[71]) exp_q.push_back(mon_r[70:0]);
      exp_ill = mon_acc && !mon_r[71] && !flush;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] fmt, input logic [5:0] op, input logic fd,
                       input logic [4:0] dest, input logic [63:0] fs, input logic [63:0] ft);
    in_fmt = fmt;
    in_opcode = op;
    in_fd = fd;
    in_dest = dest;
    in_fs = fs;
    in_ft = ft;
  endtask

  task automatic send(input logic [4:0] fmt, input logic [5:0] op, input logic fd,
                      input logic [4:0] dest, input logic [63:0] fs, input logic [63:0] ft);
    logic ok;
    ok = 1'b0;
    drive(fmt, op, fd, dest, fs, ft);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) check("send_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    check("drain_idle", busy, 1'b0);
  endtask

  // Called right after send(): result must show exactly two cycles after the accept.
  task automatic expect_result(input string tag, input logic [1:0] we, input logic [31:0] lo);
    @(negedge clk);
    check({tag, "_early"}, out_valid, 1'b0);
    tick();
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_we"}, out_we, we);
    check({tag, "_data"}, out_data[31:0], lo);
    tick();
  endtask

  logic [63:0] ps_fs[3];
  logic [63:0] ps_ft[3];
  int          k, nacc;
  logic        acc;
  int          kind;
  logic [22:0] frac;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_we", out_we, 2'b00);
    check("rst_out_dest", out_dest, 5'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_busy", busy, 1'b0);
`ifdef CVT_STATS_EN
    check("rst_cnt_done", cnt_done, '0);
    check("rst_cnt_illegal", cnt_illegal, '0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // 1: CVT.S.W of 3
    out_ready = 1'b1;
    send(5'h14, 6'h20, 1'b0, 5'd1, 64'h3, 64'h0);
    expect_result("t1", 2'b01, 32'h4040_0000);

    // 2: CVT.W.S of 1.5 ties to even
    send(5'h10, 6'h24, 1'b1, 5'd2, 64'h3FC0_0000, 64'h0);
    expect_result("t2", 2'b10, 32'h0000_0002);

    // 3: three CVT.PS.S ops against four stalled cycles
    ps_fs[0] = 64'h3F80_0000; ps_ft[0] = 64'h4000_0000;
    ps_fs[1] = 64'hC040_0000; ps_ft[1] = 64'h4080_0000;
    ps_fs[2] = 64'h40A0_0000; ps_ft[2] = 64'hBF00_0000;
    out_ready = 1'b0;
    k = 0;
    nacc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(5'h10, 6'h26, 1'b0, 5'(10 + k), ps_fs[k], ps_ft[k]);
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (c >= 2) check("t3_ready_low", in_ready, 1'b0);
      tick();
      if (acc) begin
        k++;
        nacc++;
      end
    end
    in_valid = 1'b0;
    check("t3_accepts", nacc, 2);
    out_ready = 1'b1;
    while (k < 3) begin
      send(5'h10, 6'h26, 1'b0, 5'(10 + k), ps_fs[k], ps_ft[k]);
      k++;
    end
    drain();

    // 4: illegal op, then a legal one
    send(5'h10, 6'h3F, 1'b0, 5'd4, 64'h1, 64'h0);
    @(negedge clk);
    check("t4_illegal_pulse", illegal, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check("t4_no_out", out_valid, 1'b0);
      tick();
      @(negedge clk);
    end
    check("t4_pulse_gone", illegal, 1'b0);
    tick();
    send(5'h14, 6'h20, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0);
    expect_result("t4", 2'b01, 32'hC0A0_0000);

    // 5: flush with both stages valid
    out_ready = 1'b0;
    send(5'h14, 6'h20, 1'b0, 5'd7, 64'h10, 64'h0);
    send(5'h14, 6'h20, 1'b0, 5'd9, 64'h20, 64'h0);
    hz_reg = 5'd7;
    flush = 1'b1;
    drive(5'h14, 6'h20, 1'b0, 5'd11, 64'h30, 64'h0);
    in_valid = 1'b1;
    @(negedge clk);
    check("t5_hz_before", hz_hit, 1'b1);
    check("t5_ready_flush", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 1'b0);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_hz_a", hz_hit, 1'b0);
    hz_reg = 5'd9;
    #1;
    check("t5_hz_b", hz_hit, 1'b0);
    tick();
    out_ready = 1'b1;

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      tick();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        kind = $urandom_range(0, 9);
        in_dest = 5'($urandom_range(0, 7));
        in_fd = 1'($urandom_range(0, 1));
        in_ft = {$urandom, $urandom};
        in_fs = {$urandom, $urandom};
        if (kind < 3) begin
          in_fmt = 5'h14; in_opcode = 6'h20;
          case ($urandom_range(0, 3))
            0: in_fs[31:0] = 32'($urandom_range(0, 100));
            1: in_fs[31:0] = -32'($urandom_range(0, 100));
            2: in_fs[31:0] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
            default: ;
          endcase
        end else if (kind < 6) begin
          in_fmt = 5'h10; in_opcode = 6'h24;
          frac = 23'($urandom) & (23'h7F_FFFF << $urandom_range(0, 22));
          in_fs[31:0] = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 165)), frac};
          if ($urandom_range(0, 15) == 0) in_fs[30:23] = 8'hFF;
        end else if (kind < 9) begin
          in_fmt = 5'h10; in_opcode = 6'h26;
        end else begin
          in_fmt = 5'($urandom_range(0, 31));
          in_opcode = 6'($urandom_range(0, 63));
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      hz_reg = 5'($urandom_range(0, 7));
    end
    drain();
    check("queue_empty", exp_q.size(), 0);
`ifdef CVT_STATS_EN
    check("cnt_done_model", cnt_done, CNT_W'(n_done));
    check("cnt_illegal_model", cnt_illegal, CNT_W'(n_ill));
`endif

    // 6: reset mid-stream, then one op after release
    out_ready = 1'b1;
    send(5'h14, 6'h20, 1'b0, 5'd3, 64'h7, 64'h0);
    send(5'h10, 6'h26, 1'b0, 5'd6, 64'h1, 64'h2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_we", out_we, 2'b00);
    check("t6_rst_data", out_data, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    send(5'h10, 6'h24, 1'b0, 5'd8, 64'h4120_0000, 64'h0);
    expect_result("t6", 2'b01, 32'd10);
    drain();
`ifdef CVT_STATS_EN
    check("t6_cnt_done", cnt_done, CNT_W'(1));
    check("t6_cnt_illegal", cnt_illegal, CNT_W'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
